// File: rtl/sd_block_reader.sv
// Streams 512-byte SD sectors from a one-word-per-cycle helper into a small output FIFO.
// Optional define SD_BLOCK_READER_MULTI_BLOCK_EN adds req_blocks for contiguous multi-sector reads.
module sd_block_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [22:0] req_sector,
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
  input  logic [7:0]  req_blocks,
`endif
  output logic        sd_setAddr,
  output logic [31:0] sd_addr,
  output logic        sd_ren,
  input  logic [31:0] sd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSetAddr, StRead, StDrain} state_e;

  state_e        state_q, state_d;
  logic [22:0]   sector_q, sector_d;
  logic [6:0]    word_q, word_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [32:0]   mem_q [FIFO_DEPTH];

  logic          push, pop, last_blk, last_word;
  logic [AW:0]   count_after_pop;

`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
  logic [7:0]    blk_q, blk_d;  // blocks still to read after the current one
  assign last_blk = (blk_q == 8'd0);
`else
  assign last_blk = 1'b1;
`endif

  assign out_valid       = (count_q != '0);
  assign pop             = out_valid & out_ready;
  assign count_after_pop = count_q - {{AW{1'b0}}, pop};
  assign last_word       = (word_q == 7'd127) && last_blk;

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign sd_setAddr = (state_q == StSetAddr);
  assign sd_addr    = sd_setAddr ? {sector_q, 9'b0} : '0;
  // A pop in the same cycle frees the slot the new word lands in.
  assign sd_ren     = (state_q == StRead) && (count_after_pop < DepthCnt) && !reset;
  assign push       = sd_ren;
  assign out_data   = out_valid ? mem_q[rd_ptr_q][31:0] : '0;
  assign out_last   = out_valid & mem_q[rd_ptr_q][32];

  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    word_d   = word_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
    blk_d    = blk_q;
`endif
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_after_pop + {{AW{1'b0}}, push};

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d  = StSetAddr;
          sector_d = req_sector;
          word_d   = '0;
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
          blk_d    = req_blocks - 8'd1;  // 0 wraps to 255, i.e. 256 blocks
`endif
        end
      end
      StSetAddr: state_d = StRead;
      StRead: begin
        if (sd_ren) begin
          word_d = word_q + 7'd1;
          if (word_q == 7'd127) begin
            if (last_blk) state_d = StDrain;
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
            else blk_d = blk_q - 8'd1;
`endif
          end
        end
      end
      StDrain: begin
        if (count_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sector_q <= '0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
      blk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      word_q   <= word_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
      blk_q    <= blk_d;
`endif
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {last_word, sd_data};
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: an SD helper model feeds address-derived words, a monitor records
// the stream and handshakes, and each scenario task compares them with the expected block.
module tb_sd_block_reader;

  localparam int Depth  = 4;
  localparam int Budget = 3000;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        req_valid  = 1'b0;
  logic        req_ready;
  logic [22:0] req_sector = '0;
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
  logic [7:0]  req_blocks = 8'd1;
`endif
  logic        sd_setAddr;
  logic [31:0] sd_addr;
  logic        sd_ren;
  logic [31:0] sd_data;
  logic        out_valid;
  logic        out_ready  = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  sd_block_reader #(.FIFO_DEPTH(Depth)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sector (req_sector),
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
    .req_blocks (req_blocks),
`endif
    .sd_setAddr (sd_setAddr),
    .sd_addr    (sd_addr),
    .sd_ren     (sd_ren),
    .sd_data    (sd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ (a >> 5) ^ 32'h0BAD_F00D;
  endfunction

  // SD helper: address register loaded by setAddr, advanced one word per read strobe.
  logic [31:0] hp_addr = '0;
  assign sd_data = word_at(hp_addr);
  always @(posedge clk) begin
    if (sd_setAddr) hp_addr <= sd_addr;
    else if (sd_ren) hp_addr <= hp_addr + 32'd4;
  end

  // Monitor state; only the monitor writes it, tasks request a clear via clr_gen.
  int          cyc = 0, clr_gen = 0, seen_gen = 0, exp_ren = 128;
  bit          mon_en = 1'b0;
  int          setaddr_cnt, ren_cnt, hs_cnt, occ, max_occ;
  int          overflow_err, overlap_err, valid_err, busy_err, gap_err, full_pp_cnt;
  int          first_ren_cyc, last_ren_cyc, setaddr_cyc, last_pop_cyc;
  logic [31:0] last_addr;
  logic [32:0] rx_q[$];
  logic        mon_pop;
  int          occ_nx;
  assign mon_pop = out_valid && out_ready;
  assign occ_nx  = occ + int'(sd_ren) - int'(mon_pop);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr_gen != seen_gen) begin
      seen_gen <= clr_gen;
      setaddr_cnt <= 0; ren_cnt <= 0; hs_cnt <= 0; occ <= 0; max_occ <= 0;
      overflow_err <= 0; overlap_err <= 0; valid_err <= 0; busy_err <= 0; gap_err <= 0;
      full_pp_cnt <= 0; first_ren_cyc <= -1; last_ren_cyc <= -1; setaddr_cyc <= -1;
      last_pop_cyc <= -1; last_addr <= 'x;
      rx_q.delete();
    end else if (mon_en && !reset) begin
      if (sd_setAddr) begin
        setaddr_cnt <= setaddr_cnt + 1;
        last_addr   <= sd_addr;
        setaddr_cyc <= cyc;
      end
      if (sd_ren) begin
        if (ren_cnt == 0) first_ren_cyc <= cyc;
        last_ren_cyc <= cyc;
        ren_cnt <= ren_cnt + 1;
        if (sd_setAddr) overlap_err <= overlap_err + 1;
        if (occ - int'(mon_pop) >= Depth) overflow_err <= overflow_err + 1;
      end
      if ((occ != 0) != out_valid) valid_err <= valid_err + 1;
      if (occ == Depth && mon_pop && sd_ren) full_pp_cnt <= full_pp_cnt + 1;
      if (occ == Depth && mon_pop && !sd_ren && setaddr_cnt > 0 && ren_cnt < exp_ren)
        gap_err <= gap_err + 1;
      if (mon_pop) begin
        rx_q.push_back({out_last, out_data});
        if (!busy) busy_err <= busy_err + 1;
        if (out_last) last_pop_cyc <= cyc;
      end
      if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;
      occ <= occ_nx;
      if (occ_nx > max_occ) max_occ <= occ_nx;
    end
  end

  int n_checks = 0, n_fail = 0;
  int done_cyc, rel_ren;
  bit done_ok;

  // mode: 0 always ready, 1 random ready, 2 stall 20 cycles after word 2, 3 hold until full
  task automatic run_req(input logic [22:0] sector, input int blocks, input int mode,
                         input bit reject, input string name);
    int          n, stall_left, bad, first_bad;
    bit          released;
    logic [31:0] base;
    logic [32:0] exp_w, got_w;
    n    = 128 * blocks;
    base = {sector, 9'b0};
    @(posedge clk); #1;
    clr_gen++;
    exp_ren   = n;
    mon_en    = 1'b1;
    out_ready = (mode == 0 || mode == 2);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_sector = sector;
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
    req_blocks = blocks[7:0];
`endif
    @(posedge clk); #1;
    req_valid  = 1'b0;
    stall_left = 20;
    released   = 1'b0;
    done_ok    = 1'b0;
    rel_ren    = 0;
    for (int i = 0; i < Budget; i++) begin
      if (!busy) begin
        done_ok  = 1'b1;
        done_cyc = cyc;
        break;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (rx_q.size() >= 2 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
        default: begin
          if (!released && occ == Depth) begin
            released  = 1'b1;
            rel_ren   = ren_cnt;
            out_ready = 1'b1;
          end
        end
      endcase
      if (reject) begin
        req_valid  = (i == 30);
        req_sector = (i == 30) ? 23'd9 : sector;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    req_valid = 1'b0;

    n_checks++;
    if (!done_ok) begin n_fail++; $display("FAIL %s done: busy still high after %0d cycles", name, Budget); end
    n_checks++;
    if (hs_cnt != 1) begin n_fail++; $display("FAIL %s handshakes: got %0d required 1", name, hs_cnt); end
    n_checks++;
    if (setaddr_cnt != 1) begin n_fail++; $display("FAIL %s setAddr pulses: got %0d required 1", name, setaddr_cnt); end
    n_checks++;
    if (last_addr !== base) begin n_fail++; $display("FAIL %s sd_addr: got %h required %h", name, last_addr, base); end
    n_checks++;
    if (ren_cnt != n) begin n_fail++; $display("FAIL %s sd_ren pulses: got %0d required %0d", name, ren_cnt, n); end
    n_checks++;
    if (overlap_err != 0 || overflow_err != 0) begin
      n_fail++;
      $display("FAIL %s ren rules: got %0d ren+setAddr, %0d ren-into-full, required 0 and 0", name, overlap_err, overflow_err);
    end
    n_checks++;
    if (valid_err != 0 || busy_err != 0 || gap_err != 0) begin
      n_fail++;
      $display("FAIL %s flow: got valid_err=%0d busy_err=%0d gap_err=%0d, required all 0", name, valid_err, busy_err, gap_err);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < n; i++) begin
      exp_w = {(i == n - 1), word_at(base + 32'(4 * i))};
      if (i < rx_q.size()) got_w = rx_q[i];
      else got_w = 'x;
      if (got_w !== exp_w) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    n_checks++;
    if (bad != 0 || rx_q.size() != n) begin
      n_fail++;
      $display("FAIL %s stream: got %0d words with %0d wrong (first %0d), required %0d exact", name, rx_q.size(), bad, first_bad, n);
    end
    n_checks++;
    if (done_cyc != last_pop_cyc + 1) begin
      n_fail++;
      $display("FAIL %s busy fall: got cycle %0d required %0d", name, done_cyc, last_pop_cyc + 1);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready after: got %b required 1", name, req_ready); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, sd_setAddr, sd_ren, out_valid, out_last, busy} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset flags: got %b required 100000",
               {req_ready, sd_setAddr, sd_ren, out_valid, out_last, busy});
    end
    n_checks++;
    if (sd_addr !== 32'd0) begin n_fail++; $display("FAIL reset sd_addr: got %h required 0", sd_addr); end
    reset = 1'b0;
  endtask

  task automatic test_single_block;
    run_req(23'd5, 1, 0, 1'b0, "single");
    n_checks++;
    if (first_ren_cyc != setaddr_cyc + 1) begin
      n_fail++;
      $display("FAIL single first ren: got cycle %0d required %0d", first_ren_cyc, setaddr_cyc + 1);
    end
    n_checks++;
    if (last_ren_cyc - first_ren_cyc != 127) begin
      n_fail++;
      $display("FAIL single ren span: got %0d required 127", last_ren_cyc - first_ren_cyc);
    end
  endtask

  task automatic test_busy_reject;
    run_req(23'd12, 1, 0, 1'b1, "reject");
  endtask

  task automatic test_backpressure;
    run_req(23'd17, 1, 2, 1'b0, "backpressure");
    n_checks++;
    if (max_occ != Depth) begin
      n_fail++;
      $display("FAIL backpressure occupancy: got max %0d required %0d", max_occ, Depth);
    end
  endtask

  task automatic test_full_pushpop;
    run_req(23'd33, 1, 3, 1'b0, "full_pushpop");
    n_checks++;
    if (full_pp_cnt != 128 - rel_ren) begin
      n_fail++;
      $display("FAIL full_pushpop throughput: got %0d push+pop cycles required %0d", full_pp_cnt, 128 - rel_ren);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 3; k++)
      run_req(23'($urandom_range(0, 32'h7F_FFFF)), 1, 1, 1'b0, "random");
  endtask

  task automatic test_reset_mid_block;
    @(posedge clk); #1;
    clr_gen++;
    exp_ren   = 128;
    mon_en    = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_sector = 23'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < Budget; i++) begin
      if (rx_q.size() >= 60) break;
      @(posedge clk); #1;
    end
    n_checks++;
    if (rx_q.size() < 60) begin n_fail++; $display("FAIL midreset reach: got %0d words required 60", rx_q.size()); end
    mon_en    = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sd_ren !== 1'b0) begin n_fail++; $display("FAIL midreset ren during reset: got %b required 0", sd_ren); end
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({req_ready, sd_setAddr, sd_ren, out_valid, out_last, busy} !== 6'b100000) begin
      n_fail++;
      $display("FAIL midreset flags: got %b required 100000",
               {req_ready, sd_setAddr, sd_ren, out_valid, out_last, busy});
    end
    n_checks++;
    if (sd_addr !== 32'd0) begin n_fail++; $display("FAIL midreset sd_addr: got %h required 0", sd_addr); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset stale word: got out_valid %b required 0", out_valid); end
    run_req(23'd0, 1, 0, 1'b0, "after_reset");
  endtask

`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
  task automatic test_multi_block;
    run_req(23'd1, 2, 0, 1'b0, "multi");
    run_req(23'($urandom_range(0, 32'h7F_FFFF)), 3, 1, 1'b0, "multi_random");
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_busy_reject();
    test_backpressure();
    test_full_pushpop();
    test_random();
    test_reset_mid_block();
`ifdef SD_BLOCK_READER_MULTI_BLOCK_EN
    test_multi_block();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
